// File: rtl/adc_ram_rdr_if.sv
// adc_ram_rdr_if: command, RAM read port and sample stream bundle for adc_ram_rdr
//   start/base_addr/num_words/busy/done : command side
//   raddr/rdat                          : adc_ram registered read port
//   s_data/s_valid/s_ready/s_last       : sample stream toward the datapath
//   slave modport = reader, master modport = its environment
interface adc_ram_rdr_if #(
    parameter int DWIDTH = 160,
    parameter int AWIDTH = 13,
    parameter int SWIDTH = 16
);
    logic              start;
    logic [AWIDTH-1:0] base_addr;
    logic [AWIDTH:0]   num_words;
    logic              busy;
    logic              done;
    logic [AWIDTH-1:0] raddr;
    logic [DWIDTH-1:0] rdat;
    logic [SWIDTH-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              s_last;
    modport slave (
        input  start, base_addr, num_words, rdat, s_ready,
        output busy, done, raddr, s_data, s_valid, s_last
    );
    modport master (
        output start, base_addr, num_words, rdat, s_ready,
        input  busy, done, raddr, s_data, s_valid, s_last
    );
endinterface

// File: rtl/adc_ram_rdr.sv
// adc_ram_rdr: streams num_words RAM words from base_addr as SWIDTH-bit samples
//   clk, rst : clock and synchronous active-high reset
//   bus      : adc_ram_rdr_if.slave (command, RAM read port, sample stream)
module adc_ram_rdr #(
    parameter int DWIDTH = 160,
    parameter int AWIDTH = 13,
    parameter int SWIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    adc_ram_rdr_if.slave bus
);
    localparam int LANES = DWIDTH / SWIDTH;
    localparam int LW    = $clog2(LANES + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            r_state, w_next;
    logic [AWIDTH-1:0] r_raddr;
    logic [AWIDTH:0]   r_rem;
    logic [AWIDTH:0]   r_pop_rem;
    logic              r_zero;
    logic              r_d1, r_d2;
    logic [DWIDTH-1:0] r_fifo [4];
    logic [1:0]        r_wp, r_rp;
    logic [2:0]        r_cnt;
    logic [DWIDTH-1:0] r_word;
    logic [LW-1:0]     r_lane;
    logic              r_valid;
    logic              r_last_word;
    logic              w_accept, w_issue, w_hs, w_end, w_pop;
    logic [1:0]        w_infl;
    logic [2:0]        w_used;
    assign w_accept = (r_state == IDLE) & bus.start;
    assign w_infl   = {1'b0, r_d1} + {1'b0, r_d2};
    // FIFO slots already promised to reads still travelling through the RAM
    assign w_used   = r_cnt + {1'b0, w_infl};
    assign w_issue  = (w_accept & (bus.num_words != '0)) |
                      ((r_state == RUN) & (r_rem != '0) & (w_used < 3'd4));
    assign w_hs     = r_valid & bus.s_ready;
    assign w_end    = r_lane == LW'(LANES - 1);
    // reload on the last lane's handshake so back-to-back words have no bubble
    assign w_pop    = (~r_valid | (w_hs & w_end)) & (r_cnt != 3'd0);
    // an empty command passes one cycle in RUN so done lands two cycles after start
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (bus.start ? RUN : IDLE) :
                 (r_state == RUN)  ? ((r_zero | (w_hs & w_end & r_last_word)) ? DONE : RUN) :
                 IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (r_d2) r_fifo[r_wp] <= bus.rdat;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_raddr     <= '0;
            r_rem       <= '0;
            r_pop_rem   <= '0;
            r_zero      <= 1'b0;
            r_d1        <= 1'b0;
            r_d2        <= 1'b0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
            r_word      <= '0;
            r_lane      <= '0;
            r_valid     <= 1'b0;
            r_last_word <= 1'b0;
        end else begin
            if (w_accept) r_zero <= bus.num_words == '0;
            if (w_issue) r_raddr <= (r_state == IDLE) ? bus.base_addr : r_raddr + AWIDTH'(1);
            r_rem <= (w_accept ? bus.num_words : r_rem) - {{AWIDTH{1'b0}}, w_issue};
            r_d1  <= w_issue;
            r_d2  <= r_d1;
            if (r_d2) r_wp <= r_wp + 2'd1;
            r_cnt <= r_cnt + {2'b0, r_d2} - {2'b0, w_pop};
            if (w_accept) r_pop_rem <= bus.num_words;
            if (w_pop) begin
                r_word      <= r_fifo[r_rp];
                r_rp        <= r_rp + 2'd1;
                r_lane      <= '0;
                r_valid     <= 1'b1;
                r_last_word <= r_pop_rem == (AWIDTH+1)'(1);
                r_pop_rem   <= r_pop_rem - (AWIDTH+1)'(1);
            end else if (w_hs) begin
                r_word <= r_word >> SWIDTH;
                r_lane <= r_lane + LW'(1);
                if (w_end) r_valid <= 1'b0;
            end
        end
    end
    assign bus.raddr   = r_raddr;
    assign bus.s_data  = r_word[SWIDTH-1:0];
    assign bus.s_valid = r_valid;
    assign bus.s_last  = r_valid & r_last_word & w_end;
    assign bus.busy    = r_state != IDLE;
    assign bus.done    = r_state == DONE;
endmodule

// File: tb/tb_adc_ram_rdr.sv
// tb_adc_ram_rdr: table-driven commands with a sample scoreboard, plus empty-command and mid-stream reset sequences
module tb_adc_ram_rdr;
    localparam int DW = 160, AW = 13, SW = 16, LANES = 10;
    typedef struct packed { logic [15:0] d; logic l; } smp_t;
    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   nw;
        int            pct;
        int            poke;
        bit            pd;
        int            n;
        logic [15:0]   first;
        logic [15:0]   last;
    } vec_t;
    logic clk = 1'b0;
    logic rst;
    smp_t q[$];
    vec_t vecs[6];
    int   errors = 0, checks = 0;
    always #5 clk = ~clk;
    adc_ram_rdr_if #(.DWIDTH(DW), .AWIDTH(AW), .SWIDTH(SW)) bus();
    adc_ram_rdr #(.DWIDTH(DW), .AWIDTH(AW), .SWIDTH(SW)) dut (.clk(clk), .rst(rst), .bus(bus));
    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int k = 0; k < LANES; k++) begin
            int v;
            v = int'(a) * 16 + k;
            w[k*SW +: SW] = v[15:0];
        end
        return w;
    endfunction
    always @(posedge clk) bus.rdat <= ram_word(bus.raddr);
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic run_cmd(input logic [AW-1:0] base, input logic [AW:0] nw, input int pct,
                           input int poke, input bit pd,
                           output int n, output logic [15:0] first, output logic [15:0] last);
        int cyc, cyc_first, hs0, hs1, limit;
        bit stalled;
        logic [16:0] held;
        logic [AW-1:0] ra, la, nlo;
        smp_t e;
        n = 0; first = '0; last = '0; hs0 = 0; hs1 = 0; cyc = 0; cyc_first = 0;
        stalled = 1'b0; held = '0;
        limit = int'(nw) * LANES * 20 + 100;
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = base; bus.num_words = nw;
        for (int w = 0; w < int'(nw); w++)
            for (int k = 0; k < LANES; k++) begin
                int v;
                v = (int'(base) + w) * 16 + k;
                e.d = v[15:0];
                e.l = (w == int'(nw) - 1) && (k == LANES - 1);
                q.push_back(e);
            end
        while (q.size() > 0 && cyc < limit) begin
            @(negedge clk);
            cyc++;
            bus.start = (cyc == poke);
            bus.base_addr = base + AW'(9);
            bus.num_words = nw + 1'b1;
            if (cyc == 1) chk("raddr_first", 32'(bus.raddr), 32'(base));
            if (stalled) chk("hold", {15'd0, bus.s_valid, bus.s_last, bus.s_data}, {15'd0, 1'b1, held});
            if (bus.s_valid && cyc_first == 0) begin
                cyc_first = cyc;
                chk("latency", cyc, 4);
            end
            bus.s_ready = $urandom_range(99) >= pct;
            if (bus.s_valid && bus.s_ready) begin
                e = q.pop_front();
                chk("sample", {15'd0, bus.s_last, bus.s_data}, {15'd0, e.l, e.d});
                if (n == 0) begin first = bus.s_data; hs0 = cyc; end
                last = bus.s_data; hs1 = cyc; n++;
                stalled = 1'b0;
            end else begin
                stalled = bus.s_valid;
                held = {bus.s_last, bus.s_data};
            end
        end
        chk("drain_timeout", q.size(), 0);
        q.delete();
        if (pct == 0) chk("rate", hs1 - hs0, n - 1);
        @(negedge clk);
        chk("done_pulse", {29'd0, bus.done, bus.busy, bus.s_valid}, 32'b110);
        bus.start = pd;
        ra = bus.raddr;
        @(negedge clk);
        bus.start = 1'b0;
        chk("idle_after", {bus.done, bus.busy, 17'd0, bus.raddr}, {2'b00, 17'd0, ra});
        nlo = nw[AW-1:0];
        la = base + nlo - AW'(1);
        chk("raddr_last", 32'(bus.raddr), 32'(la));
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int n, cnt, g;
        logic [15:0] f, l;
        logic [AW-1:0] r0;
        vecs[0] = '{13'd0,    14'd2,  0,  0,  1'b0, 20,  16'h0000, 16'h0019};
        vecs[1] = '{13'd8191, 14'd3,  0,  0,  1'b0, 30,  16'hFFF0, 16'h0019};
        vecs[2] = '{13'd0,    14'd64, 50, 0,  1'b0, 640, 16'h0000, 16'h03F9};
        vecs[3] = '{13'd40,   14'd2,  20, 6,  1'b1, 20,  16'h0280, 16'h0299};
        vecs[4] = '{13'd8190, 14'd5,  0,  0,  1'b1, 50,  16'hFFE0, 16'h0029};
        vecs[5] = '{13'd7,    14'd1,  70, 15, 1'b0, 10,  16'h0070, 16'h0079};
        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.num_words = '0; bus.s_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_raddr", 32'(bus.raddr), 0);
        chk("reset_ctl", {12'd0, bus.s_data, bus.s_valid, bus.s_last, bus.busy, bus.done}, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i].base, vecs[i].nw, vecs[i].pct, vecs[i].poke, vecs[i].pd, n, f, l);
            chk($sformatf("v%0d_count", i), n, vecs[i].n);
            chk($sformatf("v%0d_first", i), 32'(f), 32'(vecs[i].first));
            chk($sformatf("v%0d_last", i), 32'(l), 32'(vecs[i].last));
        end
        @(negedge clk);
        r0 = bus.raddr;
        bus.start = 1'b1; bus.base_addr = 13'd77; bus.num_words = '0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("zero_busy", {30'd0, bus.busy, bus.done}, 32'b10);
        @(negedge clk);
        chk("zero_done", {29'd0, bus.done, bus.busy, bus.s_valid}, 32'b110);
        @(negedge clk);
        chk("zero_idle", {30'd0, bus.done, bus.busy}, 0);
        chk("zero_raddr", 32'(bus.raddr), 32'(r0));
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 13'd200; bus.num_words = 14'd4; bus.s_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0; g = 0;
        while (cnt < 6 && g < 100) begin
            if (bus.s_valid) cnt++;
            @(negedge clk);
            g++;
        end
        chk("rst_at7", {15'd0, bus.s_valid, bus.s_data}, {15'd0, 1'b1, 16'h0C86});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_raddr", 32'(bus.raddr), 0);
        chk("midrst_ctl", {12'd0, bus.s_data, bus.s_valid, bus.s_last, bus.busy, bus.done}, 0);
        run_cmd(13'd100, 14'd1, 0, 0, 1'b0, n, f, l);
        chk("post_rst_count", n, 10);
        chk("post_rst_first", 32'(f), 32'h0640);
        chk("post_rst_last", 32'(l), 32'h0649);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
